// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : WIDTH-bit valid/ready ALU with single-cycle ops, iterative
//             signed/unsigned multiply and divide, and output backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  input  logic [3:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_err
);

  localparam int MSB = WIDTH - 1;
  localparam int SW  = CW - 1;
  localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [2*WIDTH-1:0]   data_q, data_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     w_sum, w_diff, w_alu;
  logic                 w_big_shift, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0]   w_acc_nxt, w_prod;
  logic [WIDTH-1:0]     w_rem_sh, w_rem_sub, w_rem_nxt, w_quo_nxt;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_fix, w_quo_fix;

  // Single-cycle result, computed straight from the live inputs at accept
  always_comb begin
    w_sum       = in_A + in_B;
    w_diff      = in_A - in_B;
    w_big_shift = |in_B[WIDTH-1:SW];
    w_alu       = '0;
    case (mode)
      4'd0: w_alu = (in_A[MSB] == in_B[MSB] && w_sum[MSB] != in_A[MSB])
                    ? (in_A[MSB] ? c_smin : c_smax) : w_sum;
      4'd1: w_alu = (in_A[MSB] != in_B[MSB] && w_diff[MSB] != in_A[MSB])
                    ? (in_A[MSB] ? c_smin : c_smax) : w_diff;
      4'd2: w_alu = in_A & in_B;
      4'd3: w_alu = in_A | in_B;
      4'd4: w_alu = in_A ^ in_B;
      4'd5: w_alu = {{(WIDTH-1){1'b0}}, in_A == in_B};
      4'd6: w_alu = {{(WIDTH-1){1'b0}}, $signed(in_A) >= $signed(in_B)};
      4'd7: w_alu = w_big_shift ? '0 : in_A >> in_B[SW-1:0];
      4'd8: w_alu = w_big_shift ? '0 : in_A << in_B[SW-1:0];
      default: w_alu = '0;
    endcase
  end

  assign w_signed = (mode == 4'd11) || (mode == 4'd12);
  assign w_a_neg  = w_signed & in_A[MSB];
  assign w_b_neg  = w_signed & in_B[MSB];
  assign w_mag_a  = w_a_neg ? -in_A : in_A;
  assign w_mag_b  = w_b_neg ? -in_B : in_B;

  assign w_acc_nxt = opa_q[0] ? acc_q + mcand_q : acc_q;
  assign w_prod    = negq_q ? -w_acc_nxt : w_acc_nxt;

  // Restoring step: the partial remainder never exceeds the divisor, so the
  // top bit shifted out of rem_q only matters for the compare.
  assign w_rem_sh  = {rem_q[MSB-1:0], opa_q[MSB]};
  assign w_ge      = {rem_q[MSB], w_rem_sh} >= {1'b0, opb_q};
  assign w_rem_sub = w_rem_sh - opb_q;
  assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh;
  assign w_quo_nxt = {opa_q[MSB-1:0], w_ge};
  assign w_quo_fix = negq_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = negr_q ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          negq_d = w_a_neg ^ w_b_neg;
          negr_d = w_a_neg;
          cnt_d  = '0;
          case (mode)
            4'd9, 4'd11: begin
              state_d = S_MUL;
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, w_mag_a};
              opa_d   = w_mag_b;
            end
            4'd10, 4'd12: begin
              if (in_B == '0) begin
                state_d = S_DONE;
                data_d  = {in_A, {WIDTH{1'b1}}};
                err_d   = 1'b1;
              end else begin
                state_d = S_DIV;
                rem_d   = '0;
                opa_d   = w_mag_a;
                opb_d   = w_mag_b;
              end
            end
            4'd13, 4'd14, 4'd15: begin
              state_d = S_DONE;
              data_d  = '0;
              err_d   = 1'b1;
            end
            default: begin
              state_d = S_DONE;
              data_d  = {{WIDTH{1'b0}}, w_alu};
              err_d   = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d   = w_acc_nxt;
        mcand_d = mcand_q << 1;
        opa_d   = opa_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == c_last) begin
          state_d = S_DONE;
          data_d  = w_prod;
          err_d   = 1'b0;
        end
      end
      S_DIV: begin
        rem_d = w_rem_nxt;
        opa_d = w_quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_last) begin
          state_d = S_DONE;
          data_d  = {w_rem_fix, w_quo_fix};
          err_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Held low through reset so upstream never sees a spurious accept window
  assign in_ready  = (state_q == S_IDLE) & rst_n;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Purpose  : Directed vector table plus multi-cycle corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, r32, ov32, or32, err32;
  logic [3:0]  m32;
  logic [31:0] a32, b32;
  logic [63:0] d32;

  logic        v16, r16, ov16, or16, err16;
  logic [3:0]  m16;
  logic [15:0] a16, b16;
  logic [31:0] d16;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_A(a32), .in_B(b32), .mode(m32), .out_valid(ov32),
    .out_ready(or32), .out_data(d32), .out_err(err32)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
    .in_A(a16), .in_B(b16), .mode(m16), .out_valid(ov16),
    .out_ready(or16), .out_data(d16), .out_err(err16)
  );

  typedef struct {
    logic [3:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] d, input logic e, input int lat);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.exp_d = d; v.exp_e = e; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  // Latency counts rising edges from the accept edge (inclusive) until out_valid
  task automatic run32(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] d, output logic e, output int lat);
    @(negedge clk);
    v32 = 1'b1; m32 = m; a32 = a; b32 = b;
    @(posedge clk); #1;
    v32 = 1'b0; a32 = ~a; b32 = 32'h5A5A_5A5A; m32 = 4'd15;
    lat = 1;
    while (ov32 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    d = d32;
    e = err32;
  endtask

  task automatic consume32;
    @(negedge clk); or32 = 1'b1;
    @(posedge clk); #1; or32 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic        e;
    int          lat;
    logic        seen;

    rst_n = 1'b0;
    v32 = 0; or32 = 0; m32 = 0; a32 = 0; b32 = 0;
    v16 = 0; or16 = 0; m16 = 0; a16 = 0; b16 = 0;

    add(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_7FFF_FFFF, 1'b0, 1);
    add(4'd0,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1);
    add(4'd0,  32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_0008, 1'b0, 1);
    add(4'd1,  32'h8000_0000, 32'h0000_0001, 64'h0000_0000_8000_0000, 1'b0, 1);
    add(4'd1,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1'b0, 1);
    add(4'd1,  32'h0000_0003, 32'h0000_0005, 64'h0000_0000_FFFF_FFFE, 1'b0, 1);
    add(4'd2,  32'h0000_F0F0, 32'h0000_FF00, 64'h0000_0000_0000_F000, 1'b0, 1);
    add(4'd3,  32'h0000_F0F0, 32'h0000_FF00, 64'h0000_0000_0000_FFF0, 1'b0, 1);
    add(4'd4,  32'h0000_F0F0, 32'h0000_FF00, 64'h0000_0000_0000_0FF0, 1'b0, 1);
    add(4'd5,  32'h0000_1234, 32'h0000_1234, 64'h0000_0000_0000_0001, 1'b0, 1);
    add(4'd5,  32'h0000_1234, 32'h0000_1235, 64'h0000_0000_0000_0000, 1'b0, 1);
    add(4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_0000_0000, 1'b0, 1);
    add(4'd6,  32'h0000_0005, 32'h0000_0005, 64'h0000_0000_0000_0001, 1'b0, 1);
    add(4'd7,  32'h8000_0000, 32'h0000_0028, 64'h0000_0000_0000_0000, 1'b0, 1);
    add(4'd7,  32'h8000_0000, 32'h0000_001F, 64'h0000_0000_0000_0001, 1'b0, 1);
    add(4'd8,  32'h0000_0001, 32'h0000_001F, 64'h0000_0000_8000_0000, 1'b0, 1);
    add(4'd8,  32'h0000_0001, 32'h0000_0020, 64'h0000_0000_0000_0000, 1'b0, 1);
    add(4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33);
    add(4'd11, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33);
    add(4'd11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33);
    add(4'd10, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 1'b0, 33);
    add(4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
    add(4'd12, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 33);
    add(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33);
    add(4'd10, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b1, 1);
    add(4'd12, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 1'b1, 1);
    add(4'd14, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0000, 1'b1, 1);
    add(4'd13, 32'hFFFF_FFFF, 32'h0000_0003, 64'h0000_0000_0000_0000, 1'b1, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, r32},  64'd0);
    chk("rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("rst_out_data",  d32,           64'd0);
    chk("rst_out_err",   {63'd0, err32}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {63'd0, r32}, 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run32(vecs[i].mode, vecs[i].a, vecs[i].b, d, e, lat);
      chk($sformatf("vec%0d_m%0d_data", i, vecs[i].mode), d, vecs[i].exp_d);
      chk($sformatf("vec%0d_m%0d_err", i, vecs[i].mode), {63'd0, e}, {63'd0, vecs[i].exp_e});
      chk($sformatf("vec%0d_m%0d_lat", i, vecs[i].mode), 64'(lat), 64'(vecs[i].exp_lat));
      consume32();
      chk($sformatf("vec%0d_handshake", i), {62'd0, ov32, r32}, 64'd1);
      chk($sformatf("vec%0d_retain", i), d32, vecs[i].exp_d);
    end

    // out_ready already high before the result: still seen for one cycle
    @(negedge clk); or32 = 1'b1;
    run32(4'd9, 32'd3, 32'd5, d, e, lat);
    chk("early_ready_lat", 64'(lat), 64'd33);
    chk("early_ready_data", d, 64'd15);
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("early_ready_drop", {62'd0, ov32, r32}, 64'd1);

    // 16-bit multiply with a stalled consumer and a competing request
    @(negedge clk);
    v16 = 1'b1; m16 = 4'd9; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    lat = 1;
    while (ov16 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul16_lat",  64'(lat), 64'd17);
    chk("mul16_data", {32'd0, d16}, 64'hFFFE_0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v16 = 1'b1; m16 = 4'd2; a16 = 16'hF0F0; b16 = 16'hFF00;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_data", i), {32'd0, d16}, 64'hFFFE_0001);
      chk($sformatf("stall%0d_flags", i), {62'd0, ov16, r16}, 64'd2);
    end
    v16 = 1'b0;
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1; or16 = 1'b0;
    chk("mul16_consume", {62'd0, ov16, r16}, 64'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ov16 === 1'b1) seen = 1'b1;
    end
    chk("mul16_not_queued", {63'd0, seen}, 64'd0);
    chk("mul16_retain", {32'd0, d16}, 64'hFFFE_0001);

    // Reset in the middle of a multiply
    @(negedge clk);
    v32 = 1'b1; m32 = 4'd9; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, ov32}, 64'd0);
    chk("midrst_ready", {63'd0, r32},  64'd0);
    chk("midrst_data",  d32,           64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", {63'd0, r32}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32 === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_output", {63'd0, seen}, 64'd0);
    run32(4'd2, 32'h0000_F0F0, 32'h0000_FF00, d, e, lat);
    chk("post_rst_and_data", d, 64'h0000_F000);
    chk("post_rst_and_lat", 64'(lat), 64'd1);
    chk("post_rst_and_err", {63'd0, e}, 64'd0);
    consume32();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
